// File: rtl/alu_result_skid_stage.sv
// Registered 2-entry skid stage for ALU results, with sticky overflow and retired-op count.
// Latency: 1 cycle from push into an empty stage to out_valid.
// Backpressure: in_ready comes only from the state register; up to 2 entries are buffered.
module alu_result_skid_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] result,
    input  logic             carryFlag,
    input  logic             zeroFlag,
    input  logic             overFlowFlag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_opcode,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_overflow,
    output logic             sticky_ovf,
    input  logic             sticky_clear,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       head_op_q, head_op_d, skid_op_q, skid_op_d;
    logic [WIDTH-1:0] head_res_q, head_res_d, skid_res_q, skid_res_d;
    logic             head_c_q, head_c_d, skid_c_q, skid_c_d;
    logic             head_z_q, head_z_d, skid_z_q, skid_z_d;
    logic             head_v_q, head_v_d, skid_v_q, skid_v_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;
    logic             push, pop;

    assign in_ready  = (state_q != S_FULL);
    assign out_valid = (state_q != S_EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_d    = state_q;
        head_op_d  = head_op_q;
        head_res_d = head_res_q;
        head_c_d   = head_c_q;
        head_z_d   = head_z_q;
        head_v_d   = head_v_q;
        skid_op_d  = skid_op_q;
        skid_res_d = skid_res_q;
        skid_c_d   = skid_c_q;
        skid_z_d   = skid_z_q;
        skid_v_d   = skid_v_q;
        unique case (state_q)
            S_EMPTY: begin
                if (push) begin
                    state_d    = S_ONE;
                    head_op_d  = opcode;
                    head_res_d = result;
                    head_c_d   = carryFlag;
                    head_z_d   = zeroFlag;
                    head_v_d   = overFlowFlag;
                end
            end
            S_ONE: begin
                if (push && pop) begin
                    head_op_d  = opcode;
                    head_res_d = result;
                    head_c_d   = carryFlag;
                    head_z_d   = zeroFlag;
                    head_v_d   = overFlowFlag;
                end else if (push) begin
                    state_d    = S_FULL;
                    skid_op_d  = opcode;
                    skid_res_d = result;
                    skid_c_d   = carryFlag;
                    skid_z_d   = zeroFlag;
                    skid_v_d   = overFlowFlag;
                end else if (pop) begin
                    state_d    = S_EMPTY;
                end
            end
            S_FULL: begin
                // Skid entry moves up to the head; input side stays closed this cycle.
                if (pop) begin
                    state_d    = S_ONE;
                    head_op_d  = skid_op_q;
                    head_res_d = skid_res_q;
                    head_c_d   = skid_c_q;
                    head_z_d   = skid_z_q;
                    head_v_d   = skid_v_q;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    // A new overflow takes priority over a same-cycle clear.
    always_comb begin
        sticky_d = sticky_q;
        if (push && overFlowFlag) begin
            sticky_d = 1'b1;
        end else if (sticky_clear) begin
            sticky_d = 1'b0;
        end
    end

    assign op_count_d = op_count_q + {{(CNT_W-1){1'b0}}, pop};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_EMPTY;
            head_op_q  <= '0;
            head_res_q <= '0;
            head_c_q   <= 1'b0;
            head_z_q   <= 1'b0;
            head_v_q   <= 1'b0;
            skid_op_q  <= '0;
            skid_res_q <= '0;
            skid_c_q   <= 1'b0;
            skid_z_q   <= 1'b0;
            skid_v_q   <= 1'b0;
            sticky_q   <= 1'b0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            head_op_q  <= head_op_d;
            head_res_q <= head_res_d;
            head_c_q   <= head_c_d;
            head_z_q   <= head_z_d;
            head_v_q   <= head_v_d;
            skid_op_q  <= skid_op_d;
            skid_res_q <= skid_res_d;
            skid_c_q   <= skid_c_d;
            skid_z_q   <= skid_z_d;
            skid_v_q   <= skid_v_d;
            sticky_q   <= sticky_d;
            op_count_q <= op_count_d;
        end
    end

    assign out_opcode   = head_op_q;
    assign out_result   = head_res_q;
    assign out_carry    = head_c_q;
    assign out_zero     = head_z_q;
    assign out_overflow = head_v_q;
    assign sticky_ovf   = sticky_q;
    assign op_count     = op_count_q;

endmodule
